// File: rtl/split_assign_driver.sv
// Loads a packed assignment vector word by word, lets the split checker settle, returns its verdict.
// Optional SPLIT_DRV_STATS_EN adds saturating result and pass counters.
module split_assign_driver #(
   parameter int VEC_W   = 551,
   parameter int WORD_W  = 32,
   parameter int CHK_LAT = 1,
   parameter int TAG_W   = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [WORD_W-1:0]   in_data,
   output logic [VEC_W-1:0]    asg_vec,
   input  logic                chk_x,
   output logic                res_valid,
   input  logic                res_ready,
   output logic                res_pass,
   output logic [TAG_W-1:0]    res_tag
`ifdef SPLIT_DRV_STATS_EN
  ,output logic [31:0]         stat_total,
   output logic [31:0]         stat_pass
`endif
);

   localparam int NW      = (VEC_W + WORD_W - 1) / WORD_W;
   localparam int WCNT_W  = (NW > 1) ? $clog2(NW) : 1;
   localparam int LAST_LO = (NW - 1) * WORD_W;
   localparam int LAST_W  = VEC_W - LAST_LO;
   localparam logic [WCNT_W-1:0] LAST_IDX  = WCNT_W'(NW - 1);
   localparam logic [3:0]        SCNT_INIT = 4'(CHK_LAT);

   typedef enum logic [1:0] {
      S_LOAD,
      S_SETTLE,
      S_REPORT
   } state_t;

   state_t            state, state_nxt;
   logic [WCNT_W-1:0] wcnt;
   logic [3:0]        scnt;
   logic              ld_hs;
   logic              last_word;
   logic              settle_done;
   logic              res_hs;
   logic [VEC_W-1:0]  asg_nxt;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_LOAD;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      ld_hs       = 1'b0;
      last_word   = 1'b0;
      settle_done = 1'b0;
      res_hs      = 1'b0;
      case (state)
         S_LOAD: begin
            ld_hs     = in_valid;
            last_word = in_valid && (wcnt == LAST_IDX);
            if (last_word) state_nxt = S_SETTLE;
         end
         S_SETTLE: begin
            settle_done = (scnt == 4'd0);
            if (settle_done) state_nxt = S_REPORT;
         end
         S_REPORT: begin
            res_hs = res_ready;
            if (res_hs) state_nxt = S_LOAD;
         end
         default: state_nxt = S_LOAD;
      endcase
   end

   assign in_ready = (state == S_LOAD);

   // Bits of the final word beyond VEC_W are dropped rather than wrapped.
   always_comb begin
      asg_nxt = asg_vec;
      for (int k = 0; k < NW - 1; k++) begin
         if (wcnt == WCNT_W'(k)) asg_nxt[k*WORD_W +: WORD_W] = in_data;
      end
      if (wcnt == LAST_IDX) asg_nxt[VEC_W-1:LAST_LO] = in_data[LAST_W-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wcnt      <= '0;
         scnt      <= '0;
         asg_vec   <= '0;
         res_valid <= 1'b0;
         res_pass  <= 1'b0;
         res_tag   <= '0;
      end else begin
         if (ld_hs) begin
            asg_vec <= asg_nxt;
            wcnt    <= last_word ? '0 : wcnt + 1'b1;
         end
         if (last_word)
            scnt <= SCNT_INIT;
         else if (state == S_SETTLE && !settle_done)
            scnt <= scnt - 4'd1;
         if (settle_done) begin
            res_valid <= 1'b1;
            res_pass  <= chk_x;
         end else if (res_hs) begin
            res_valid <= 1'b0;
            res_tag   <= res_tag + 1'b1;
         end
      end
   end

`ifdef SPLIT_DRV_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_total <= '0;
         stat_pass  <= '0;
      end else if (res_hs) begin
         stat_total <= sat_inc(stat_total);
         if (res_pass) stat_pass <= sat_inc(stat_pass);
      end
   end
`endif

endmodule

// File: tb/tb_split_assign_driver.sv
// Randomized bench for split_assign_driver: reference vector built from word list, verdict timing by cycle count.
module tb_split_assign_driver;

   localparam int VEC_W   = 551;
   localparam int WORD_W  = 32;
   localparam int CHK_LAT = 1;
   localparam int TAG_W   = 16;
   localparam int NW      = (VEC_W + WORD_W - 1) / WORD_W;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [WORD_W-1:0] in_data = '0;
   logic [VEC_W-1:0]  asg_vec;
   logic              chk_x = 1'b0;
   logic              res_valid;
   logic              res_ready = 1'b0;
   logic              res_pass;
   logic [TAG_W-1:0]  res_tag;
`ifdef SPLIT_DRV_STATS_EN
   logic [31:0]       stat_total;
   logic [31:0]       stat_pass;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int exp_tag = 0;
   int exp_total = 0;
   int exp_pass = 0;
   logic [VEC_W-1:0]  exp_vec = '0;
   logic [WORD_W-1:0] words [NW];

   split_assign_driver #(
      .VEC_W(VEC_W), .WORD_W(WORD_W), .CHK_LAT(CHK_LAT), .TAG_W(TAG_W)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .asg_vec(asg_vec), .chk_x(chk_x),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_pass(res_pass), .res_tag(res_tag)
`ifdef SPLIT_DRV_STATS_EN
     ,.stat_total(stat_total), .stat_pass(stat_pass)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [VEC_W-1:0] obs, input logic [VEC_W-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: each word shifted to its slot, everything above VEC_W discarded.
   function automatic logic [VEC_W-1:0] model_vec();
      logic [NW*WORD_W-1:0] acc;
      acc = '0;
      for (int k = 0; k < NW; k++)
         acc = acc | ((NW*WORD_W)'(words[k]) << (k * WORD_W));
      return VEC_W'(acc);
   endfunction

   task automatic check_idle(input string tag);
      check({tag, "_rv"}, VEC_W'(res_valid), VEC_W'(0));
      check({tag, "_rdy"}, VEC_W'(in_ready), VEC_W'(1));
      check({tag, "_tag"}, VEC_W'(res_tag), VEC_W'(exp_tag));
`ifdef SPLIT_DRV_STATS_EN
      check({tag, "_stot"}, VEC_W'(stat_total), VEC_W'(exp_total));
      check({tag, "_spas"}, VEC_W'(stat_pass), VEC_W'(exp_pass));
`endif
   endtask

   // mode 0: random words with stalls; 1: words 1..NW, chk_x=1; 2: zeros with all-ones last word
   task automatic run_txn(input int mode, input int hold);
      logic p;
      p = 1'b0;
      for (int k = 0; k < NW; k++) begin
         case (mode)
            1:       words[k] = WORD_W'(k + 1);
            2:       words[k] = (k == NW - 1) ? '1 : '0;
            default: words[k] = $urandom;
         endcase
      end
      for (int k = 0; k < NW; k++) begin
         if (mode == 0) begin
            repeat ($urandom_range(0, 2)) begin
               in_valid = 1'b0;
               in_data  = $urandom;
               tick();
            end
         end
         in_valid = 1'b1;
         in_data  = words[k];
         check("load_rdy", VEC_W'(in_ready), VEC_W'(1));
         tick();
      end
      for (int i = 0; i <= CHK_LAT; i++) begin
         p        = (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
         chk_x    = p;
         in_valid = 1'b1;
         in_data  = $urandom;
         check("settle_rv", VEC_W'(res_valid), VEC_W'(0));
         check("settle_rdy", VEC_W'(in_ready), VEC_W'(0));
         tick();
      end
      exp_vec = model_vec();
      check("res_valid", VEC_W'(res_valid), VEC_W'(1));
      check("res_pass", VEC_W'(res_pass), VEC_W'(p));
      check("res_tag", VEC_W'(res_tag), VEC_W'(exp_tag));
      check("asg_vec", asg_vec, exp_vec);
      if (mode == 1) begin
         check("vec_lo", VEC_W'(asg_vec[31:0]), VEC_W'(1));
         check("vec_hi", VEC_W'(asg_vec[550:544]), VEC_W'(7'h12));
      end
      if (mode == 2) begin
         check("trunc_hi", VEC_W'(asg_vec[550:544]), VEC_W'(7'h7F));
         check("trunc_lo", VEC_W'(asg_vec[31:0]), VEC_W'(0));
      end
      for (int i = 0; i < hold; i++) begin
         in_valid  = 1'b1;
         in_data   = $urandom;
         chk_x     = ~chk_x;
         res_ready = 1'b0;
         tick();
         check("hold_rv", VEC_W'(res_valid), VEC_W'(1));
         check("hold_pass", VEC_W'(res_pass), VEC_W'(p));
         check("hold_tag", VEC_W'(res_tag), VEC_W'(exp_tag));
         check("hold_rdy", VEC_W'(in_ready), VEC_W'(0));
         check("hold_vec", asg_vec, exp_vec);
      end
      in_valid  = 1'b0;
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      exp_tag   = (exp_tag + 1) % (1 << TAG_W);
      exp_total = exp_total + 1;
      if (p) exp_pass = exp_pass + 1;
      check_idle("post");
      check("post_vec", asg_vec, exp_vec);
   endtask

   initial begin
      // Reset asserted while a word is offered.
      in_valid = 1'b1;
      in_data  = 32'h1;
      tick();
      tick();
      check_idle("rst");
      check("rst_vec", asg_vec, VEC_W'(0));
      rst_n = 1'b1;

      run_txn(1, 5);
      run_txn(2, 0);
      for (int t = 0; t < 20; t++) run_txn(0, $urandom_range(0, 3));

      // Partial load of 7 words, stall, then asynchronous reset.
      for (int k = 0; k < 7; k++) begin
         in_valid = 1'b1;
         in_data  = $urandom | 32'h1;
         tick();
      end
      in_valid = 1'b0;
      repeat (3) tick();
      check("stall_rdy", VEC_W'(in_ready), VEC_W'(1));
      #2 rst_n = 1'b0;
      #1;
      exp_tag   = 0;
      exp_total = 0;
      exp_pass  = 0;
      check_idle("arst");
      check("arst_vec", asg_vec, VEC_W'(0));
      tick();
      rst_n = 1'b1;

      run_txn(0, 1);
      run_txn(2, 2);
      for (int t = 0; t < 6; t++) run_txn(0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
